uart_rx_fifo: RTL and testbench

- Synthesizable, parametrised UART receiver with a buffered read side, for the management SoC and its DV benches.
- Successor to the fixed-format testbench UART monitor:
  - programmable bit period and data width;
  - optional parity;
  - framing/overflow detection;
  - FIFO with valid/ready pop interface.
- Sits on the core clock domain. Serial input comes from the SoC UART TX line or a pad; the read side feeds a bench checker or a wishbone register front-end.

---
 rtl/uart_rx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through FIFO.
// The bit period is programmable through clk_div, latched at the start of each frame.
// Framing errors, overflow and break are flagged.
// Optional even-parity checking is compiled in when UART_RX_PARITY_EN is defined.
// That build adds a PARITY state and a sticky parity_err output.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          core_clk,
    input  logic                          core_rst,
    input  logic                          rx,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              clk_div,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          break_det,
    input  logic                          clr_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_sync_reg;
    logic rx_prev_reg;
    logic fall_edge;

    // Two-flop synchroniser plus a delayed copy for edge detection; idles high
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign fall_edge = rx_prev_reg & ~rx_sync_reg;

    // ------------------------------------------------------------------
    // Receive FSM and bit-timing datapath
    // ------------------------------------------------------------------
    state_t                 state_reg;
    state_t                 state_next;
    logic [DIV_W-1:0]       div_eff;
    logic [DIV_W-1:0]       div_reg;
    logic [DIV_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       bit_idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tick;
    logic                   last_bit;

    logic                   push;
    logic                   frame_set;
    logic                   break_set;
`ifdef UART_RX_PARITY_EN
    logic                   parity_set;
    logic                   parity_bad_reg;
    logic                   parity_err_reg;
`endif

    // Divisors below 4 leave too little room for a mid-bit sample, so clamp them
    assign div_eff  = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
    assign tick     = (cnt_reg == '0);
    assign last_bit = (bit_idx_reg == IDX_W'(DATA_BITS - 1));

    // State register
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; dropping enable abandons the frame from any state
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state_next = ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state_next = rx_sync_reg ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync_reg) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output strobes: push, error and break events raised at the sample points
    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
        break_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        if (enable) begin
            case (state_reg)
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick && (rx_sync_reg != ^shift_reg)) begin
                        parity_set = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (rx_sync_reg) begin
`ifdef UART_RX_PARITY_EN
                            push = ~parity_bad_reg;
`else
                            push = 1'b1;
`endif
                        end else begin
                            frame_set = 1'b1;
                            break_set = (shift_reg == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit timer, bit index and shift register; divisor latched at frame start
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            div_reg     <= DIV_W'(4);
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE) begin
                if (enable && fall_edge) begin
                    div_reg     <= div_eff;
                    cnt_reg     <= (div_eff >> 1) - DIV_W'(1);
                    bit_idx_reg <= '0;
                end
            end else begin
                if (tick) begin
                    cnt_reg <= div_reg - DIV_W'(1);
                end else begin
                    cnt_reg <= cnt_reg - DIV_W'(1);
                end
                if (state_reg == ST_DATA && tick) begin
                    shift_reg   <= {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                    bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Remember a parity mismatch so the STOP state can suppress the push
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            parity_bad_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            parity_bad_reg <= 1'b0;
        end else if (parity_set) begin
            parity_bad_reg <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [LVL_W-1:0]       level_reg;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   overflow_set;

    assign full         = (level_reg == LVL_W'(FIFO_DEPTH));
    assign pop          = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en        = push & (~full | pop);
    assign overflow_set = push & full & ~pop;

    // Storage write; contents need no reset since level gates visibility
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_valid   = (level_reg != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level = level_reg;

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    logic overflow_reg;
    logic frame_err_reg;
    logic break_det_reg;

    // Sticky flags; a new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            break_det_reg <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            break_det_reg <= break_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            parity_err_reg <= 1'b0;
        end else if (parity_set) begin
            parity_err_reg <= 1'b1;
        end else if (clr_err) begin
            parity_err_reg <= 1'b0;
        end
    end

    assign parity_err = parity_err_reg;
`endif

    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;
    assign break_det = break_det_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (8 data bits, 16-entry FIFO).
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        rx       = 1'b1;
    logic        enable   = 1'b0;
    logic [15:0] clk_div  = 16'd16;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        frame_err;
    logic        break_det;
    logic        clr_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    int checks   = 0;
    int failures = 0;
    int break_total = 0;

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .rx         (rx),
        .enable     (enable),
        .clk_div    (clk_div),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .clr_err    (clr_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 core_clk = ~core_clk;

    // Count break pulses as seen away from the active edge
    always @(negedge core_clk) begin
        if (break_det) break_total <= break_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic send_bit(input logic b, input int div);
        rx = b;
        repeat (div) @(negedge core_clk);
    endtask

    task automatic send_head(input logic [7:0] d, input int div);
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) send_bit(d[i], div);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
        send_head(d, div);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, div);
`endif
        send_bit(stop, div);
        rx = 1'b1;
        $display("sent frame data=0x%02h stop=%b div=%0d", d, stop, div);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        @(negedge core_clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        enable   = 1'b1;
        idle(3);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rd_data); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if ({overflow, frame_err, break_det} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {overflow, frame_err, break_det}); end
        core_rst = 1'b0;
        idle(5);
    endtask

    task automatic test_basic();
        int b0;
        b0 = break_total;
        clk_div = 16'd16;
        send_head(8'hA5, 16);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0, 16);
`endif
        rx = 1'b1;
        idle(10);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL basic_early: got rd_valid=%b want 0 before stop sample", rd_valid); end
        idle(1);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_rise: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h want a5", rd_data); end
        checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL basic_level: got %0d want 1", fifo_level); end
        idle(10);
        checks++; if ({overflow, frame_err, break_total - b0} !== {2'b00, 32'd0}) begin failures++; $display("FAIL basic_flags: got ovf=%b ferr=%b brk=%0d want 0 0 0", overflow, frame_err, break_total - b0); end
        $display("received data=0x%02h level=%0d", rd_data, fifo_level);
        pop_one();
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL basic_pop_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_false_start();
        int b0;
        b0 = break_total;
        send_bit(1'b0, 4);
        rx = 1'b1;
        idle(40);
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL false_start_level: got %0d want 0", fifo_level); end
        checks++; if ({overflow, frame_err, break_total - b0} !== {2'b00, 32'd0}) begin failures++; $display("FAIL false_start_flags: got ovf=%b ferr=%b brk=%0d want 0 0 0", overflow, frame_err, break_total - b0); end
        send_frame(8'h96, 1'b1, 16);
        idle(8);
        checks++; if (rd_data !== 8'h96 || fifo_level !== 5'd1) begin failures++; $display("FAIL false_start_recover: got data=%h level=%0d want 96 1", rd_data, fifo_level); end
        pop_one();
    endtask

    task automatic test_break();
        int b0;
        b0 = break_total;
        send_frame(8'h00, 1'b0, 16);
        idle(20);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL break_frame_err: got %b want 1", frame_err); end
        checks++; if (break_total - b0 !== 1) begin failures++; $display("FAIL break_pulse_count: got %0d want 1", break_total - b0); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL break_level: got %0d want 0", fifo_level); end
        send_frame(8'h3C, 1'b1, 16);
        idle(8);
        checks++; if (rd_data !== 8'h3C || fifo_level !== 5'd1) begin failures++; $display("FAIL break_next_frame: got data=%h level=%0d want 3c 1", rd_data, fifo_level); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL break_sticky: got %b want 1", frame_err); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL break_clear: got %b want 0", frame_err); end
        pop_one();
    endtask

    task automatic test_div_clamp();
        clk_div = 16'd2;
        send_frame(8'hC3, 1'b1, 4);
        idle(12);
        checks++; if (rd_data !== 8'hC3 || fifo_level !== 5'd1) begin failures++; $display("FAIL div_clamp: got data=%h level=%0d want c3 1", rd_data, fifo_level); end
        pop_one();
        clk_div = 16'd16;
        idle(4);
    endtask

    task automatic test_overflow();
        logic ok;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 16);
            idle(4);
        end
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ok = (rd_valid === 1'b1) && (rd_data === 8'(i));
            checks++; if (!ok) begin failures++; $display("FAIL ovf_drain_%0d: got valid=%b data=%h want 1 %h", i, rd_valid, rd_data, 8'(i)); end
            @(negedge core_clk);
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin failures++; $display("FAIL ovf_empty: got valid=%b level=%0d want 0 0", rd_valid, fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_enable_abort();
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 16);
        enable = 1'b0;
        rx     = 1'b1;
        idle(30);
        enable = 1'b1;
        idle(30);
        send_frame(8'h5A, 1'b1, 16);
        idle(20);
        checks++; if (fifo_level !== 5'd1 || rd_data !== 8'h5A) begin failures++; $display("FAIL enable_abort: got level=%0d data=%h want 1 5a", fifo_level, rd_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL enable_no_err: got %b want 0", frame_err); end
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 1'b1, 16);
        idle(4);
        send_frame(8'h00, 1'b0, 16);
        idle(20);
        checks++; if (fifo_level !== 5'd1 || frame_err !== 1'b1) begin failures++; $display("FAIL rst_pre: got level=%0d ferr=%b want 1 1", fifo_level, frame_err); end
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        core_rst = 1'b1;
        idle(1);
        checks++; if ({rd_valid, rd_data, fifo_level} !== 14'd0) begin failures++; $display("FAIL rst_mid_fifo: got valid=%b data=%h level=%0d want 0 00 0", rd_valid, rd_data, fifo_level); end
        checks++; if ({overflow, frame_err, break_det} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags: got %b want 000", {overflow, frame_err, break_det}); end
        core_rst = 1'b0;
        rx       = 1'b1;
        idle(200);
        checks++; if (fifo_level !== 5'd0 || frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_discard: got level=%0d ferr=%b want 0 0", fifo_level, frame_err); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par, input int div);
        send_head(d, div);
        send_bit(par, div);
        send_bit(1'b1, div);
        $display("sent frame data=0x%02h parity=%b div=%0d", d, par, div);
    endtask

    task automatic test_parity();
        send_frame_par(8'h07, 1'b1, 16);
        idle(8);
        checks++; if (fifo_level !== 5'd1 || rd_data !== 8'h07) begin failures++; $display("FAIL par_good: got level=%0d data=%h want 1 07", fifo_level, rd_data); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_good_flag: got %b want 0", parity_err); end
        pop_one();
        send_frame_par(8'h07, 1'b0, 16);
        idle(8);
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
        checks++; if (fifo_level !== 5'd0 || frame_err !== 1'b0) begin failures++; $display("FAIL par_bad_push: got level=%0d ferr=%b want 0 0", fifo_level, frame_err); end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_clear: got %b want 0", parity_err); end
    endtask
`endif

    initial begin
        @(negedge core_clk);
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_div_clamp();
        test_overflow();
        test_enable_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
